// File: rtl/al_accel_bpbuf_rpt_pkg.sv
// Shared encodings for the accelerator bypass/replay buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package al_accel_bpbuf_rpt_pkg;

    // Buffer operating mode, latched while the buffer is empty.
    typedef enum logic {
        BPBUF_FIFO = 1'b0,
        BPBUF_RPT  = 1'b1
    } bpbuf_mode_e;

    // Replay sequencing: LOAD collects a set, PLAY streams it out.
    typedef enum logic {
        LOAD = 1'b0,
        PLAY = 1'b1
    } bpbuf_state_e;

endpackage

// File: rtl/al_accel_bpbuf_mem.sv
// DEPTH x WIDTH register array, one write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates the write enable.
module al_accel_bpbuf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage clears to zero so the head word reads 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/al_accel_bpbuf_rpt.sv
// Show-ahead FIFO / replay buffer between the load path and the PE array.
// Latency: 1 cycle load-to-head on an empty buffer; replay starts the cycle after sealing.
// Backpressure: ld_ready drops when full or playing; do_valid holds until do_ready; enb=0 freezes both.
module al_accel_bpbuf_rpt
    import al_accel_bpbuf_rpt_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             clr,
    input  logic             mode,
    input  logic [CNT_W-1:0] rpt_num,
    input  logic [WIDTH-1:0] bpbuf_di,
    input  logic             bpbuf_ld_valid,
    input  logic             bpbuf_ld_last,
    output logic             bpbuf_ld_ready,
    output logic [WIDTH-1:0] bpbuf_do,
    output logic             bpbuf_do_valid,
    input  logic             bpbuf_do_ready,
    output logic [AW:0]      bpbuf_count,
    output logic             bpbuf_full,
    output logic             bpbuf_empty,
    output logic             replay_done
);

    localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    bpbuf_state_e     state_q, state_d;
    bpbuf_mode_e      mode_q, eff_mode;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, set_len_q;
    logic [CNT_W-1:0] pass_q, passes_q;
    logic             replay_done_q;
    logic             load_fire, out_fire, seal, pass_wrap, last_pass;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign bpbuf_full  = (count_q == COUNT_MAX);
    assign bpbuf_empty = (count_q == '0);
    assign bpbuf_count = count_q;
    assign replay_done = replay_done_q;

    // While empty in LOAD the live mode input governs the next load; otherwise the latched one.
    assign eff_mode  = (state_q == LOAD && bpbuf_empty) ? bpbuf_mode_e'(mode) : mode_q;
    assign pass_wrap = ({1'b0, rd_ptr_q} == set_len_q - 1'b1);
    assign last_pass = (pass_q == passes_q - 1'b1);

    // Handshake outputs, fire decode and next state from registers plus enb.
    always_comb begin
        state_d        = state_q;
        bpbuf_ld_ready = 1'b0;
        bpbuf_do_valid = 1'b0;
        load_fire      = 1'b0;
        out_fire       = 1'b0;
        seal           = 1'b0;
        case (state_q)
            LOAD: begin
                bpbuf_ld_ready = enb & ~bpbuf_full;
                bpbuf_do_valid = enb & ~bpbuf_empty & (mode_q == BPBUF_FIFO);
            end
            PLAY: bpbuf_do_valid = enb;
            default: ;
        endcase
        load_fire = enb & bpbuf_ld_valid & bpbuf_ld_ready;
        out_fire  = enb & bpbuf_do_valid & bpbuf_do_ready;
        if (state_q == LOAD && eff_mode == BPBUF_RPT && load_fire &&
            (bpbuf_ld_last || count_q == COUNT_MAX - 1'b1)) begin
            seal    = 1'b1;
            state_d = PLAY;
        end
        if (state_q == PLAY && out_fire && pass_wrap && last_pass) begin
            state_d = LOAD;
        end
        if (clr) begin
            state_d = LOAD;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, occupancy, pass counting and the done pulse; pointers return to 0 whenever the buffer empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q        <= BPBUF_FIFO;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            set_len_q     <= '0;
            pass_q        <= '0;
            passes_q      <= '0;
            replay_done_q <= 1'b0;
        end else begin
            replay_done_q <= 1'b0;
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                pass_q   <= '0;
            end else if (enb) begin
                if (state_q == LOAD) begin
                    if (bpbuf_empty) begin
                        mode_q <= eff_mode;
                    end
                    if (seal) begin
                        count_q   <= count_q + 1'b1;
                        set_len_q <= count_q + 1'b1;
                        passes_q  <= (rpt_num == '0) ? CNT_W'(1) : rpt_num;
                        pass_q    <= '0;
                        rd_ptr_q  <= '0;
                        wr_ptr_q  <= '0;
                    end else begin
                        case ({load_fire, out_fire})
                            2'b10: begin
                                count_q  <= count_q + 1'b1;
                                wr_ptr_q <= ptr_inc(wr_ptr_q);
                            end
                            2'b01: begin
                                count_q <= count_q - 1'b1;
                                if (count_q == 1) begin
                                    wr_ptr_q <= '0;
                                    rd_ptr_q <= '0;
                                end else begin
                                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                                end
                            end
                            2'b11: begin
                                wr_ptr_q <= ptr_inc(wr_ptr_q);
                                rd_ptr_q <= ptr_inc(rd_ptr_q);
                            end
                            default: ;
                        endcase
                    end
                end else if (out_fire) begin
                    if (pass_wrap) begin
                        rd_ptr_q <= '0;
                        if (last_pass) begin
                            count_q       <= '0;
                            wr_ptr_q      <= '0;
                            pass_q        <= '0;
                            replay_done_q <= 1'b1;
                        end else begin
                            pass_q <= pass_q + 1'b1;
                        end
                    end else begin
                        rd_ptr_q <= ptr_inc(rd_ptr_q);
                    end
                end
            end
        end
    end

    al_accel_bpbuf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (load_fire & ~clr),
        .waddr (wr_ptr_q),
        .wdata (bpbuf_di),
        .raddr (rd_ptr_q),
        .rdata (bpbuf_do)
    );

endmodule

// File: tb/tb_al_accel_bpbuf_rpt.sv
module tb_al_accel_bpbuf_rpt;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enb = 1'b0;
    logic             clr = 1'b0;
    logic             mode = 1'b0;
    logic [CNT_W-1:0] rpt_num = '0;
    logic [WIDTH-1:0] bpbuf_di = '0;
    logic             bpbuf_ld_valid = 1'b0;
    logic             bpbuf_ld_last = 1'b0;
    logic             bpbuf_ld_ready;
    logic [WIDTH-1:0] bpbuf_do;
    logic             bpbuf_do_valid;
    logic             bpbuf_do_ready = 1'b0;
    logic [AW:0]      bpbuf_count;
    logic             bpbuf_full;
    logic             bpbuf_empty;
    logic             replay_done;

    al_accel_bpbuf_rpt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .enb            (enb),
        .clr            (clr),
        .mode           (mode),
        .rpt_num        (rpt_num),
        .bpbuf_di       (bpbuf_di),
        .bpbuf_ld_valid (bpbuf_ld_valid),
        .bpbuf_ld_last  (bpbuf_ld_last),
        .bpbuf_ld_ready (bpbuf_ld_ready),
        .bpbuf_do       (bpbuf_do),
        .bpbuf_do_valid (bpbuf_do_valid),
        .bpbuf_do_ready (bpbuf_do_ready),
        .bpbuf_count    (bpbuf_count),
        .bpbuf_full     (bpbuf_full),
        .bpbuf_empty    (bpbuf_empty),
        .replay_done    (replay_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stored words as a queue, replay as (set, position, pass).
    logic [WIDTH-1:0] mq[$];
    bit               m_mode, m_play, m_done;
    int               m_pos, m_pass, m_passes;

    always @(posedge clk or posedge reset) begin : model
        bit ldr, dov, push, pop, done_now;
        if (reset) begin
            mq.delete();
            m_mode = 0; m_play = 0; m_done = 0;
            m_pos = 0; m_pass = 0; m_passes = 1;
        end else begin
            done_now = 0;
            if (clr) begin
                mq.delete();
                m_play = 0; m_pos = 0; m_pass = 0;
            end else if (enb) begin
                if (!m_play && mq.size() == 0) m_mode = mode;
                ldr  = !m_play && mq.size() < DEPTH;
                dov  = m_play || (!m_mode && mq.size() > 0);
                push = bpbuf_ld_valid && ldr;
                pop  = dov && bpbuf_do_ready;
                if (!m_mode) begin
                    if (pop)  void'(mq.pop_front());
                    if (push) mq.push_back(bpbuf_di);
                end else if (!m_play) begin
                    if (push) begin
                        mq.push_back(bpbuf_di);
                        if (bpbuf_ld_last || mq.size() == DEPTH) begin
                            m_play = 1; m_pos = 0; m_pass = 0;
                            m_passes = (rpt_num == 0) ? 1 : int'(rpt_num);
                        end
                    end
                end else if (pop) begin
                    m_pos++;
                    if (m_pos == mq.size()) begin
                        m_pos = 0;
                        m_pass++;
                        if (m_pass == m_passes) begin
                            mq.delete();
                            m_play = 0; m_pass = 0;
                            done_now = 1;
                        end
                    end
                end
            end
            m_done = done_now;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int  sz;
        bit  exp_ldr, exp_dov;
        if (!reset) begin
            sz      = mq.size();
            exp_ldr = enb && !m_play && sz < DEPTH;
            exp_dov = enb && (m_play || (!m_mode && sz > 0));
            chk("ld_ready", bpbuf_ld_ready, exp_ldr);
            chk("do_valid", bpbuf_do_valid, exp_dov);
            chk("count", bpbuf_count, sz);
            chk("full", bpbuf_full, sz == DEPTH);
            chk("empty", bpbuf_empty, sz == 0);
            chk("replay_done", replay_done, m_done);
            if (exp_dov) chk("do", bpbuf_do, m_play ? mq[m_pos] : mq[0]);
        end
    end

    // Observed output stream and done pulses for the hand-computed checks.
    logic [WIDTH-1:0] obs[$];
    int               done_pulses = 0;
    always @(negedge clk) begin
        if (!reset && enb && bpbuf_do_valid && bpbuf_do_ready) obs.push_back(bpbuf_do);
        if (!reset && replay_done) done_pulses++;
    end

    logic [WIDTH-1:0] ev [12];

    task automatic chk_seq(input string name, input int n);
        chk({name, "_len"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++) chk(name, obs[i], ev[i]);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] w, input bit last);
        bpbuf_ld_valid = 1'b1;
        bpbuf_di       = w;
        bpbuf_ld_last  = last;
        cyc();
        bpbuf_ld_valid = 1'b0;
        bpbuf_ld_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (replay_done) begin
                seen = 1;
                break;
            end
        end
        chk("replay_done_seen", seen, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        enb = 1'b1;
        @(negedge clk);
        chk("rst_ld_ready", bpbuf_ld_ready, 1'b1);
        chk("rst_do_valid", bpbuf_do_valid, 1'b0);
        chk("rst_do", bpbuf_do, 32'h0);
        chk("rst_empty", bpbuf_empty, 1'b1);
        chk("rst_count", bpbuf_count, 0);
        cyc();

        // FIFO fill to full, then drain in order
        mode = 1'b0;
        push(32'h5876063e, 0); push(32'haabb7788, 0); push(32'h11, 0); push(32'h22, 0);
        @(negedge clk);
        chk("fifo_full", bpbuf_full, 1'b1);
        chk("fifo_full_ld_ready", bpbuf_ld_ready, 1'b0);
        chk("fifo_full_count", bpbuf_count, 4);
        cyc();
        obs.delete();
        bpbuf_do_ready = 1'b1;
        repeat (4) cyc();
        bpbuf_do_ready = 1'b0;
        @(negedge clk);
        chk("fifo_drained_empty", bpbuf_empty, 1'b1);
        ev = '{32'h5876063e, 32'haabb7788, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_seq("fifo_order", 4);
        cyc();

        // Simultaneous push/pop at count 2 for 10 cycles, then drain
        obs.delete();
        push(32'h100, 0); push(32'h101, 0);
        bpbuf_ld_valid = 1'b1;
        bpbuf_do_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bpbuf_di = 32'h102 + i;
            cyc();
        end
        bpbuf_ld_valid = 1'b0;
        @(negedge clk);
        chk("pushpop_count", bpbuf_count, 2);
        cyc();
        cyc();
        bpbuf_do_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_empty", bpbuf_empty, 1'b1);
        ev = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105,
               32'h106, 32'h107, 32'h108, 32'h109, 32'h10a, 32'h10b};
        chk_seq("pushpop_order", 12);
        cyc();

        // Replay: A,B,C x3
        mode = 1'b1;
        rpt_num = 8'd3;
        cyc();
        obs.delete();
        done_pulses = 0;
        push(32'ha0a0, 0); push(32'hb1b1, 0); push(32'hc2c2, 1);
        @(negedge clk);
        chk("rpt_ld_ready", bpbuf_ld_ready, 1'b0);
        chk("rpt_do_valid", bpbuf_do_valid, 1'b1);
        chk("rpt_count", bpbuf_count, 3);
        chk("rpt_head", bpbuf_do, 32'ha0a0);
        cyc();
        bpbuf_do_ready = 1'b1;
        wait_done(20);
        chk("rpt_done_ld_ready", bpbuf_ld_ready, 1'b1);
        chk("rpt_done_count", bpbuf_count, 0);
        cyc();
        bpbuf_do_ready = 1'b0;
        ev = '{32'ha0a0, 32'hb1b1, 32'hc2c2, 32'ha0a0, 32'hb1b1, 32'hc2c2,
               32'ha0a0, 32'hb1b1, 32'hc2c2, 0, 0, 0};
        chk_seq("rpt_order", 9);
        repeat (3) cyc();
        chk("rpt_done_pulses", done_pulses, 1);

        // Auto-seal with rpt_num = 0: one pass of four words
        rpt_num = 8'd0;
        obs.delete();
        done_pulses = 0;
        push(32'hd0, 0); push(32'hd1, 0); push(32'hd2, 0); push(32'hd3, 0);
        @(negedge clk);
        chk("seal_full", bpbuf_full, 1'b1);
        chk("seal_do_valid", bpbuf_do_valid, 1'b1);
        cyc();
        bpbuf_do_ready = 1'b1;
        wait_done(12);
        cyc();
        bpbuf_do_ready = 1'b0;
        ev = '{32'hd0, 32'hd1, 32'hd2, 32'hd3, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_seq("seal_order", 4);
        repeat (2) cyc();
        chk("seal_done_pulses", done_pulses, 1);

        // Freeze mid-PLAY, then clear
        rpt_num = 8'd2;
        push(32'he0, 0); push(32'he1, 1);
        bpbuf_do_ready = 1'b1;
        cyc();
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_do_valid", bpbuf_do_valid, 1'b0);
            cyc();
        end
        enb = 1'b1;
        bpbuf_do_ready = 1'b0;
        @(negedge clk);
        chk("frz_resume_valid", bpbuf_do_valid, 1'b1);
        chk("frz_resume_do", bpbuf_do, 32'he1);
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_count", bpbuf_count, 0);
        chk("clr_ld_ready", bpbuf_ld_ready, 1'b1);
        chk("clr_do_valid", bpbuf_do_valid, 1'b0);
        cyc();

        // Reset asserted mid-load
        mode = 1'b0;
        cyc();
        push(32'hf0, 0); push(32'hf1, 0);
        @(negedge clk);
        chk("preload_count", bpbuf_count, 2);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_count", bpbuf_count, 0);
        chk("rst2_empty", bpbuf_empty, 1'b1);
        chk("rst2_do_valid", bpbuf_do_valid, 1'b0);
        chk("rst2_do", bpbuf_do, 32'h0);
        chk("rst2_ld_ready", bpbuf_ld_ready, 1'b1);
        chk("rst2_replay_done", replay_done, 1'b0);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
